// File: rtl/spi_ctrl.sv
// Bus-facing front end for the SPI master core: TX/RX byte FIFOs, a
// 4-register map (DATA, STATUS, CTRL, LEVEL) and a level interrupt.
module spi_ctrl #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 4,
    parameter int P_AW    = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sel,
    input  logic               i_we,
    input  logic [1:0]         i_addr,
    input  logic [31:0]        i_wdata,
    output logic [31:0]        o_rdata,
    output logic               o_cpol,
    output logic               o_cpha,
    output logic               o_tx_en,
    output logic [P_WIDTH-1:0] o_tx_data,
    input  logic               i_ready,
    input  logic [P_WIDTH-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_irq
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;

    localparam logic [P_AW:0] FULL_CNT = (P_AW+1)'(P_DEPTH);

    state_t             state, state_nxt;
    logic [3:0]         ctrl;
    logic               tx_ovf, rx_ovf;
    logic [P_WIDTH-1:0] tx_mem [P_DEPTH];
    logic [P_WIDTH-1:0] rx_mem [P_DEPTH];
    logic [P_AW-1:0]    tx_wp, tx_rp, rx_wp, rx_rp;
    logic [P_AW:0]      tx_cnt, rx_cnt;
    logic [P_WIDTH-1:0] tx_data;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    logic rd_acc, wr_acc, busy;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic data_wr, stat_wr, ctrl_wr;

    assign unused_wdata = ^i_wdata[31:P_WIDTH];

    assign rd_acc   = i_sel & ~i_we;
    assign wr_acc   = i_sel & i_we;
    assign data_wr  = wr_acc & (i_addr == 2'd0);
    assign stat_wr  = wr_acc & (i_addr == 2'd1);
    assign ctrl_wr  = wr_acc & (i_addr == 2'd2);
    assign busy     = (state != IDLE);

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);

    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign tx_pop   = (state == LAUNCH);
    assign tx_push  = data_wr & (~tx_full | tx_pop);
    assign rx_pop   = rd_acc & (i_addr == 2'd0) & ~rx_empty;
    assign rx_push  = i_rx_valid & (~rx_full | rx_pop);

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ctrl[2] && !tx_empty && i_ready) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (i_rx_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_tx_en   = (state == LAUNCH);
        o_tx_data = tx_data;
        o_cpol    = ctrl[0];
        o_cpha    = ctrl[1];
    end

    // Launch data is captured on entry to LAUNCH and held until the next launch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                        tx_data <= '0;
        else if (state == IDLE && state_nxt == LAUNCH)    tx_data <= tx_mem[tx_rp];
    end

    // ---------------- FIFOs ----------------
    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[tx_wp] <= i_wdata[P_WIDTH-1:0];
        if (rx_push) rx_mem[rx_wp] <= i_rx_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl   <= '0;
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl[3:2] <= i_wdata[3:2];
                if (!busy) ctrl[1:0] <= i_wdata[1:0];
            end
            if (data_wr && tx_full && !tx_pop)   tx_ovf <= 1'b1;
            else if (stat_wr && i_wdata[5])      tx_ovf <= 1'b0;
            if (i_rx_valid && rx_full && !rx_pop) rx_ovf <= 1'b1;
            else if (stat_wr && i_wdata[6])       rx_ovf <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (i_addr)
            2'd0: if (!rx_empty) rd_mux = 32'(rx_mem[rx_rp]);
            2'd1: rd_mux = {25'd0, rx_ovf, tx_ovf, busy, rx_empty, rx_full, tx_empty, tx_full};
            2'd2: rd_mux = {28'd0, ctrl};
            2'd3: rd_mux = {16'd0, 8'(rx_cnt), 8'(tx_cnt)};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rdata <= '0;
            o_irq   <= 1'b0;
        end else begin
            if (rd_acc) o_rdata <= rd_mux;
            o_irq <= ctrl[3] & (~rx_empty | (tx_empty & ~busy) | rx_ovf | tx_ovf);
        end
    end

endmodule

// File: doc/spi_ctrl.md
Name: spi_ctrl

Overview:
- Bus-facing front end for the SPI master core; sits directly upstream of it.
- Buffers CPU bytes in a TX FIFO and launches one core transfer per byte using the core's i_tx_en/i_tx_data/o_ready handshake.
- Captures every o_rx_valid byte from the core into an RX FIFO.
- Exposes a 4-register map (DATA, STATUS, CTRL, LEVEL) plus a level interrupt.

Parameters:
- P_WIDTH, 8: SPI word width; must match the core's P_WIDTH.
- P_DEPTH, 4: entries per FIFO; power of two, at least 2.
- P_AW, 2: log2(P_DEPTH).

Ports:
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_sel  in  1  bus access strobe, one cycle per access.
- i_we  in  1  1 = write, 0 = read; qualified by i_sel.
- i_addr  in  2  register select: 0 DATA, 1 STATUS, 2 CTRL, 3 LEVEL.
- i_wdata  in  32  write data.
- o_rdata  out  32  registered read data.
- o_cpol  out  1  to core i_cpol.
- o_cpha  out  1  to core i_cpha.
- o_tx_en  out  1  one-cycle launch pulse to core i_tx_en.
- o_tx_data  out  P_WIDTH  to core i_tx_data; held stable from launch until the next launch.
- i_ready  in  1  from core o_ready.
- i_rx_data  in  P_WIDTH  from core o_rx_data.
- i_rx_valid  in  1  from core o_rx_valid; one-cycle pulse.
- o_irq  out  1  level interrupt.

Behaviour:
- Reset (asynchronous, immediate effect):
  - Both FIFOs emptied; FSM forced to IDLE.
  - CTRL = 0, sticky flags = 0.
  - o_rdata = 0, o_tx_en = 0, o_tx_data = 0, o_cpol = 0, o_cpha = 0, o_irq = 0.
  - Reset mid-transfer aborts bookkeeping only. An i_rx_valid arriving after reset release is still pushed into the RX FIFO.
- CTRL register (addr 2, read/write):
  - bit0 cpol, bit1 cpha, bit2 enable, bit3 irq_en.
  - Writes to bits 1:0 are ignored while busy; bits 3:2 always update.
- DATA register (addr 0):
  - Write pushes i_wdata[P_WIDTH-1:0] into the TX FIFO.
  - If TX is full, the byte is dropped and tx_ovf is set.
  - Read pops the RX FIFO; data is zero-extended onto o_rdata.
  - Read with RX empty returns 0, pops nothing, and sets no flag.
- STATUS register (addr 1):
  - Read: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 busy, bit5 tx_ovf, bit6 rx_ovf.
  - Write 1 to bit5 or bit6 clears that sticky flag. Other bits are read-only.
- LEVEL register (addr 3, read-only): [7:0] TX count, [15:8] RX count; counts run 0..P_DEPTH.
- Unmapped read bits return 0.
- Read latency: o_rdata updates on the edge after an i_sel & !i_we cycle and holds until the next read. Writes take effect on that same edge.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE -> LAUNCH when enable=1, TX not empty, and i_ready=1.
  - LAUNCH (one cycle): o_tx_en=1; o_tx_data = TX head; TX pops. Always -> WAIT.
  - WAIT -> IDLE on i_rx_valid.
  - busy = (state != IDLE).
  - Clearing enable mid-transfer lets the current byte finish; no new launch follows.
- RX capture: every i_rx_valid pushes i_rx_data, in any FSM state. If RX is full (with no simultaneous pop), the new byte is discarded and rx_ovf is set.
- Simultaneous events:
  - Bus push and FSM pop of TX in the same cycle both succeed, including when TX is full; count is unchanged.
  - i_rx_valid push and bus DATA read of RX in the same cycle both succeed, including when RX is full; no rx_ovf.
  - The read returns the old head.
- FIFO pointers are P_AW bits and wrap modulo P_DEPTH; counts are P_AW+1 bits.
- o_irq = irq_en & (!rx_empty | (tx_empty & !busy) | rx_ovf | tx_ovf), registered, so it lags by one cycle.

Test Plan:
- Reset, then CTRL=0x4, write DATA 0x90, with a core model that loops sdo back to sdi -> exactly one o_tx_en pulse with o_tx_data=0x90; after i_rx_valid, LEVEL=0x0100 and DATA read returns 0x90.
- CTRL writes 0x5/0x6/0x7 with one byte each (0x91, 0x92, 0x93) -> o_cpol/o_cpha equal 1/0, 0/1, 1/1 at each launch; a CTRL write of 0x4 during WAIT leaves o_cpol/o_cpha unchanged.
- enable=0, write 5 bytes 0xA0..0xA4 -> LEVEL TX=4, STATUS tx_full=1, tx_ovf=1, no launch; set enable -> bytes launched in order 0xA0..0xA3 (0xA4 dropped); write 0x20 to STATUS -> tx_ovf=0.
- Inject 5 i_rx_valid pulses (0x10..0x14) with no reads -> rx_full=1, rx_ovf=1; reads return 0x10..0x13 then 0.
- RX full plus i_rx_valid (0x55) in the same cycle as a DATA read -> read returns the old head, no rx_ovf, RX count stays 4, and 0x55 is read last.
- Assert i_rst during WAIT with 2 bytes queued -> all outputs 0 and LEVEL=0 immediately; after release, no o_tx_en until new writes.
